// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the architectural register file / rename table.
//   XLEN     : data width of architectural registers
//   NREG     : number of architectural registers (x0 hardwired to zero)
//   TAG_W    : ROB tag width; tag value NO_DEP (0) means "operand ready"
//   IDX_W    : register index width actually decoded
package reg_file_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 5;
  localparam int IDX_W = 5;

  // ROB entry identifier
  typedef logic [TAG_W-1:0] rob_entry_t;

  localparam rob_entry_t NO_DEP = '0;

  // Issue hands over 6-bit register fields; only the low IDX_W bits name a register.
  function automatic logic [IDX_W-1:0] reg_idx(input logic [5:0] raw);
    return raw[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One operand lookup: register index -> (value, producing ROB tag).
//   idx          in  register index
//   regs, tags   in  current architectural values and rename tags (x1..x(NREG-1))
//   bypass_en    in  commit forwarding allowed this cycle
//   commit_rd/commit_tag/commit_value in  retiring instruction
//   v, q         out operand value and tag (q==0 -> v is final)
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int NREG  = reg_file_pkg::NREG,
  parameter int TAG_W = reg_file_pkg::TAG_W,
  parameter int XLEN  = reg_file_pkg::XLEN
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [XLEN-1:0]  regs [1:NREG-1],
  input  logic [TAG_W-1:0] tags [1:NREG-1],
  input  logic             bypass_en,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_value,
  output logic [XLEN-1:0]  v,
  output logic [TAG_W-1:0] q
);

  always_comb begin
    v = '0;
    q = TAG_W'(NO_DEP);
    if (idx != '0) begin
      v = regs[idx];
      q = tags[idx];
      // Forward the retiring result only if it comes from the producer the
      // table still names; a newer rename of the same register keeps its tag.
      if (bypass_en && commit_rd == idx && tags[idx] == commit_tag) begin
        v = commit_value;
        q = TAG_W'(NO_DEP);
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file plus rename-tag table.
//   clk, rst (async, active-high), rdy (global enable; low holds state)
//   rs1_to_reg/rs2_to_reg : operand indices (bit 5 ignored)
//   rd_to_reg, issue_valid, issue_tag : rename of rd at issue
//   Vj/Qj/Vk/Qk_from_reg : combinational operand value/tag, Q==0 means ready
//   commit_valid/commit_rd/commit_tag/commit_value : ROB retirement
//   flush : drop all renames
module reg_file
  import reg_file_pkg::*;
#(
  parameter int NREG  = reg_file_pkg::NREG,
  parameter int TAG_W = reg_file_pkg::TAG_W,
  parameter int XLEN  = reg_file_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [5:0]       rs1_to_reg,
  input  logic [5:0]       rs2_to_reg,
  input  logic [5:0]       rd_to_reg,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic [XLEN-1:0]  Vj_from_reg,
  output logic [XLEN-1:0]  Vk_from_reg,
  output logic [TAG_W-1:0] Qj_from_reg,
  output logic [TAG_W-1:0] Qk_from_reg,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_value,
  input  logic             flush
);

  logic [XLEN-1:0]  regs [1:NREG-1];
  logic [TAG_W-1:0] tags [1:NREG-1];

  logic [IDX_W-1:0] rs1_idx;
  logic [IDX_W-1:0] rs2_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             bypass_en;
  logic             unused_hi_bits;

  assign rs1_idx = reg_idx(rs1_to_reg);
  assign rs2_idx = reg_idx(rs2_to_reg);
  assign rd_idx  = reg_idx(rd_to_reg);
  assign unused_hi_bits = ^{rs1_to_reg[5], rs2_to_reg[5], rd_to_reg[5]};

  // Forwarding is gated by reset so outputs read as zero for the whole reset window.
  assign bypass_en = rdy && commit_valid && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= '0;
        tags[r] <= TAG_W'(NO_DEP);
      end
    end else if (rdy) begin
      for (int r = 1; r < NREG; r++) begin
        // Values retire even during a flush: committed results are architectural.
        if (commit_valid && commit_rd == IDX_W'(r))
          regs[r] <= commit_value;
        // Tag priority: flush, then a new rename, then clearing by the matching commit.
        if (flush)
          tags[r] <= TAG_W'(NO_DEP);
        else if (issue_valid && rd_idx == IDX_W'(r))
          tags[r] <= issue_tag;
        else if (commit_valid && commit_rd == IDX_W'(r) && tags[r] == commit_tag)
          tags[r] <= TAG_W'(NO_DEP);
      end
    end
  end

  reg_file_read_port #(.NREG(NREG), .TAG_W(TAG_W), .XLEN(XLEN)) u_rs1_port (
    .idx          (rs1_idx),
    .regs         (regs),
    .tags         (tags),
    .bypass_en    (bypass_en),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
    .v            (Vj_from_reg),
    .q            (Qj_from_reg)
  );

  reg_file_read_port #(.NREG(NREG), .TAG_W(TAG_W), .XLEN(XLEN)) u_rs2_port (
    .idx          (rs2_idx),
    .regs         (regs),
    .tags         (tags),
    .bypass_en    (bypass_en),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
    .v            (Vk_from_reg),
    .q            (Qk_from_reg)
  );

  // Tag 0 means "no dependency", so an issuing instruction can never be given it.
  a_issue_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
    !(issue_valid && issue_tag == '0));

endmodule
